// File: rtl/mips_if_pkg.sv
// Shared types and defaults for the instruction-fetch redirect logic.
package mips_if_pkg;

  // Fetch sequencer state.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_JR   = 2'd1,
    SLOT2_DLY = 2'd2
  } if_state_e;

  // Where the next fetch PC comes from in a given cycle.
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_EXC  = 3'd1,
    SRC_ERET = 3'd2,
    SRC_BR1  = 3'd3,
    SRC_BR2  = 3'd4,
    SRC_JR   = 3'd5
  } redir_src_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VEC_DEF    = 32'hbfc0_0380;
  localparam logic [31:0] PAIR_BYTES_DEF = 32'd8;

  // A fetch pair must be 8-byte aligned; only a real fetch can fault.
  function automatic logic pc_misaligned(input logic [31:0] pc_v, input logic valid_v);
    return valid_v && (pc_v[2:0] != 3'b000);
  endfunction

endpackage

// File: rtl/if_redirect_hold.sv
// One-entry redirect buffer: holds a resolved branch/JR target until it can be applied.
module if_redirect_hold
  import mips_if_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic [31:0] load_target_i,
  input  logic        load_slot2_i,
  output logic        valid_o,
  output logic [31:0] target_o,
  output logic        slot2_o
);

  logic        valid_q;
  logic [31:0] target_q;
  logic        slot2_q;

  // Entry update: clear beats drain beats load; a full entry ignores new loads.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q  <= 1'b0;
      target_q <= 32'h0000_0000;
      slot2_q  <= 1'b0;
    end else if (clr_i) begin
      valid_q  <= 1'b0;
    end else if (drain_i) begin
      valid_q  <= 1'b0;
    end else if (load_i && !valid_q) begin
      valid_q  <= 1'b1;
      target_q <= load_target_i;
      slot2_q  <= load_slot2_i;
    end else begin
      valid_q  <= valid_q;
    end
  end

  assign valid_o  = valid_q;
  assign target_o = target_q;
  assign slot2_o  = slot2_q;

endmodule

// File: rtl/if_redirect_ctrl.sv
// Dual-issue fetch PC sequencer: picks the next 64-bit fetch pair address and
// drives flush/kill controls towards IF_1.
module if_redirect_ctrl
  import mips_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC    = EXC_VEC_DEF,
  parameter logic [31:0] PAIR_BYTES = PAIR_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] cp0_epc,
  input  logic        br1_taken,
  input  logic        br2_taken,
  input  logic [31:0] br_target,
  input  logic        jr_req,
  input  logic        jr_slot2,
  input  logic        jr_data_ok,
  input  logic [31:0] jr_data,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        flush_if,
  output logic        kill_slot2,
  output logic        adel,
  output logic        busy_jr
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        flush_q, flush_d;
  logic        kill_q, kill_d;
  logic        adel_q;
  logic        busy_q;
  logic        jr_slot2_q, jr_slot2_d;

  redir_src_e  new_src_s, top_src_s;
  logic [31:0] new_tgt_s;
  logic        new_slot2_s;
  logic        new_wait_s;

  logic        hold_clr_s, hold_load_s, hold_drain_s;
  logic        hold_valid_s, hold_slot2_s;
  logic [31:0] hold_target_s;

  logic [31:0] pc_plus_s;
  logic [31:0] seq_pc_s;

  // Next pair address wraps modulo 2^32; the first fetch after reset re-uses RESET_PC.
  assign pc_plus_s = pc_q + PAIR_BYTES;
  assign seq_pc_s  = pc_valid_q ? pc_plus_s : pc_q;

  if_redirect_hold u_hold (
    .clk_i         (clk),
    .rst_n_i       (reset),
    .clr_i         (hold_clr_s),
    .load_i        (hold_load_s),
    .drain_i       (hold_drain_s),
    .load_target_i (new_tgt_s),
    .load_slot2_i  (new_slot2_s),
    .valid_o       (hold_valid_s),
    .target_o      (hold_target_s),
    .slot2_o       (hold_slot2_s)
  );

  // Decode this cycle's branch/JR request; slot 1 beats slot 2, WAIT_JR only listens for JR data.
  always_comb begin
    new_src_s   = SRC_SEQ;
    new_tgt_s   = br_target;
    new_slot2_s = 1'b0;
    new_wait_s  = 1'b0;
    case (state_q)
      RUN: begin
        if (br1_taken) begin
          new_src_s = SRC_BR1;
        end else if (jr_req && !jr_slot2) begin
          if (jr_data_ok) begin
            new_src_s = SRC_JR;
            new_tgt_s = jr_data;
          end else begin
            new_wait_s = 1'b1;
          end
        end else if (br2_taken) begin
          new_src_s   = SRC_BR2;
          new_slot2_s = 1'b1;
        end else if (jr_req) begin
          new_slot2_s = 1'b1;
          if (jr_data_ok) begin
            new_src_s = SRC_JR;
            new_tgt_s = jr_data;
          end else begin
            new_wait_s = 1'b1;
          end
        end else begin
          new_src_s = SRC_SEQ;
        end
      end
      WAIT_JR: begin
        if (jr_data_ok) begin
          new_src_s   = SRC_JR;
          new_tgt_s   = jr_data;
          new_slot2_s = jr_slot2_q;
        end else begin
          new_src_s = SRC_SEQ;
        end
      end
      default: begin
        new_src_s = SRC_SEQ;
      end
    endcase
  end

  // Exceptions and ERET pre-empt everything, including a stall.
  assign top_src_s = exc_req  ? SRC_EXC  :
                     eret_req ? SRC_ERET : new_src_s;

  // Next-state selection for PC, controls, FSM state and the hold buffer.
  always_comb begin
    pc_d         = pc_q;
    pc_valid_d   = pc_valid_q;
    flush_d      = 1'b0;
    kill_d       = kill_q;
    state_d      = state_q;
    jr_slot2_d   = jr_slot2_q;
    hold_clr_s   = 1'b0;
    hold_load_s  = 1'b0;
    hold_drain_s = 1'b0;
    case (top_src_s)
      SRC_EXC: begin
        pc_d       = EXC_VEC;
        pc_valid_d = 1'b1;
        flush_d    = 1'b1;
        kill_d     = 1'b0;
        state_d    = RUN;
        hold_clr_s = 1'b1;
      end
      SRC_ERET: begin
        pc_d       = cp0_epc;
        pc_valid_d = 1'b1;
        flush_d    = 1'b1;
        kill_d     = 1'b0;
        state_d    = RUN;
        hold_clr_s = 1'b1;
      end
      default: begin
        if (stall) begin
          // Everything frozen; a resolved request is parked (first one wins).
          hold_load_s = (new_src_s != SRC_SEQ);
        end else if (state_q == SLOT2_DLY) begin
          // Delay-slot pair already fetched: jump to the parked target now.
          pc_d         = hold_target_s;
          pc_valid_d   = 1'b1;
          flush_d      = 1'b1;
          kill_d       = 1'b0;
          hold_drain_s = 1'b1;
          state_d      = RUN;
        end else if (hold_valid_s) begin
          // Replay a request parked during a stall; any new request is dropped.
          if (hold_slot2_s) begin
            pc_d       = pc_plus_s;
            pc_valid_d = 1'b1;
            kill_d     = 1'b1;
            state_d    = SLOT2_DLY;
          end else begin
            pc_d         = hold_target_s;
            pc_valid_d   = 1'b1;
            flush_d      = 1'b1;
            kill_d       = 1'b0;
            hold_drain_s = 1'b1;
            state_d      = RUN;
          end
        end else if (new_src_s != SRC_SEQ) begin
          if (new_slot2_s) begin
            // Fetch the delay-slot pair first, keep the target for next cycle.
            pc_d        = pc_plus_s;
            pc_valid_d  = 1'b1;
            kill_d      = 1'b1;
            hold_load_s = 1'b1;
            state_d     = SLOT2_DLY;
          end else begin
            pc_d       = new_tgt_s;
            pc_valid_d = 1'b1;
            flush_d    = 1'b1;
            kill_d     = 1'b0;
            state_d    = RUN;
          end
        end else if (new_wait_s) begin
          pc_valid_d = 1'b0;
          kill_d     = 1'b0;
          jr_slot2_d = jr_slot2;
          state_d    = WAIT_JR;
        end else if (state_q == WAIT_JR) begin
          pc_valid_d = 1'b0;
          kill_d     = 1'b0;
        end else begin
          pc_d       = seq_pc_s;
          pc_valid_d = 1'b1;
          kill_d     = 1'b0;
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      kill_q     <= 1'b0;
      adel_q     <= 1'b0;
      busy_q     <= 1'b0;
      jr_slot2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      kill_q     <= kill_d;
      adel_q     <= pc_misaligned(pc_d, pc_valid_d);
      busy_q     <= (state_d == WAIT_JR);
      jr_slot2_q <= jr_slot2_d;
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign flush_if   = flush_q;
  assign kill_slot2 = kill_q;
  assign adel       = adel_q;
  assign busy_jr    = busy_q;

endmodule
